// File: rtl/gpio_bank.sv
// GPIO bank: bus-mapped data/direction registers, pad input synchronisers,
// per-pin edge detection with sticky W1C status and a level interrupt.
module gpio_bank #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [2:0]       bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata,
  output logic             bus_rvalid,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    A_DATA_OUT   = 3'd0,
    A_DIR        = 3'd1,
    A_DATA_IN    = 3'd2,
    A_IRQ_EN     = 3'd3,
    A_EDGE_SEL   = 3'd4,
    A_IRQ_STATUS = 3'd5,
    A_SET        = 3'd6,
    A_CLR        = 3'd7
  } addr_e;

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] WARM_MAX = CW'(SYNC_STAGES + 1);

  addr_e addr;
  logic [WIDTH-1:0] data_out, dir, irq_en, edge_sel, irq_status;
  logic [WIDTH-1:0] prev, data_in, evt, w1c, rd_mux;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [CW-1:0] warm_cnt;
  logic armed;

  assign addr    = addr_e'(bus_addr);
  assign data_in = sync[SYNC_STAGES-1];
  assign armed   = (warm_cnt == WARM_MAX);
  assign pad_out = data_out;
  assign pad_oe  = dir;
  assign irq     = |(irq_status & irq_en);

  // Detection stays masked until the synchroniser and prev hold real pad
  // levels, so pins already high at reset release do not look like edges.
  always_comb begin
    evt = '0;
    if (armed)
      evt = (data_in & ~prev & edge_sel) | (~data_in & prev & ~edge_sel);
  end

  always_comb begin
    w1c = '0;
    if (bus_we && addr == A_IRQ_STATUS)
      w1c = bus_wdata;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_DATA_OUT:   rd_mux = data_out;
      A_DIR:        rd_mux = dir;
      A_DATA_IN:    rd_mux = data_in;
      A_IRQ_EN:     rd_mux = irq_en;
      A_EDGE_SEL:   rd_mux = edge_sel;
      A_IRQ_STATUS: rd_mux = irq_status;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      prev     <= '0;
      warm_cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad_in};
      prev <= data_in;
      if (!armed)
        warm_cnt <= warm_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
      edge_sel <= '1;
    end else if (bus_we) begin
      case (addr)
        A_DATA_OUT: data_out <= bus_wdata;
        A_DIR:      dir      <= bus_wdata;
        A_IRQ_EN:   irq_en   <= bus_wdata;
        A_EDGE_SEL: edge_sel <= bus_wdata;
        A_SET:      data_out <= data_out | bus_wdata;
        A_CLR:      data_out <= data_out & ~bus_wdata;
        default:    ;
      endcase
    end
  end

  // New events are OR-ed in after the clear, so a coincident event survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq_status <= '0;
    else
      irq_status <= (irq_status & ~w1c) | evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_re;
      if (bus_re)
        bus_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios plus random traffic,
// compared every cycle against a behavioural model kept in the bench.
module tb_gpio_bank;
  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         bus_we, bus_re;
  logic [2:0]   bus_addr;
  logic [W-1:0] bus_wdata, bus_rdata, pad_in, pad_out, pad_oe;
  logic         bus_rvalid, irq;

  int errors = 0;
  int checks = 0;

  gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .bus_we(bus_we), .bus_re(bus_re),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .pad_in(pad_in), .pad_out(pad_out),
    .pad_oe(pad_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pads[k] is the pad level sampled k+1 edges ago, so the
  // visible input is S edges old and an event compares it with S+1 edges old.
  logic [W-1:0] m_out, m_dir, m_en, m_esel, m_stat, m_rdata;
  logic         m_rvalid;
  logic [W-1:0] pads [0:S];
  int           n_edges;

  always @(posedge clk or posedge rst) begin : model
    logic [W-1:0] ev, w1c, rv;
    if (rst) begin
      m_out <= '0; m_dir <= '0; m_en <= '0; m_esel <= '1; m_stat <= '0;
      m_rdata <= '0; m_rvalid <= 1'b0; n_edges <= 0;
      for (int k = 0; k <= S; k++) pads[k] <= '0;
    end else begin
      ev = '0;
      if (n_edges + 1 >= S + 2)
        ev = (pads[S-1] & ~pads[S] & m_esel) | (~pads[S-1] & pads[S] & ~m_esel);
      n_edges <= (n_edges < 1000) ? n_edges + 1 : n_edges;
      w1c = (bus_we && bus_addr == 3'd5) ? bus_wdata : '0;
      m_stat <= (m_stat & ~w1c) | ev;
      if (bus_we)
        case (bus_addr)
          3'd0: m_out  <= bus_wdata;
          3'd1: m_dir  <= bus_wdata;
          3'd3: m_en   <= bus_wdata;
          3'd4: m_esel <= bus_wdata;
          3'd6: m_out  <= m_out | bus_wdata;
          3'd7: m_out  <= m_out & ~bus_wdata;
          default: ;
        endcase
      if (bus_re) begin
        case (bus_addr)
          3'd0: rv = m_out;
          3'd1: rv = m_dir;
          3'd2: rv = pads[S-1];
          3'd3: rv = m_en;
          3'd4: rv = m_esel;
          3'd5: rv = m_stat;
          default: rv = '0;
        endcase
        m_rdata <= rv;
      end
      m_rvalid <= bus_re;
      pads[0] <= pad_in;
      for (int k = 1; k <= S; k++) pads[k] <= pads[k-1];
    end
  end

  always @(negedge clk) begin
    chk("pad_out", pad_out, m_out);
    chk("pad_oe",  pad_oe,  m_dir);
    chk("irq",     irq,     |(m_stat & m_en));
    chk("rvalid",  bus_rvalid, m_rvalid);
    chk("rdata",   bus_rdata,  m_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [W-1:0] exp);
    bus_re = 1'b1; bus_addr = a;
    tick();
    bus_re = 1'b0;
    chk({name, "_rvalid"}, bus_rvalid, 1);
    chk(name, bus_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
    pad_in = 16'hFFFF;
    tick(); tick();
    chk("rst_pad_out", pad_out, 0);
    chk("rst_pad_oe", pad_oe, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rvalid", bus_rvalid, 0);
    rst = 1'b0;

    // Pads held high through reset release must not flag edges.
    repeat (S + 3) tick();
    rd("warm_status", 3'd5, 16'h0000);
    rd("warm_datain", 3'd2, 16'hFFFF);
    rd("warm_esel", 3'd4, 16'hFFFF);

    // Output path
    wr(3'd1, 16'h00FF);
    wr(3'd0, 16'h0F0F);
    wr(3'd6, 16'hF000);
    wr(3'd7, 16'h000F);
    chk("out_pad_oe", pad_oe, 16'h00FF);
    chk("out_pad_out", pad_out, 16'hFF00);
    chk("model_out", m_out, 16'hFF00);
    rd("out_read", 3'd0, 16'hFF00);
    tick();
    chk("out_rvalid_drop", bus_rvalid, 0);
    rd("set_read", 3'd6, 16'h0000);
    wr(3'd2, 16'h1234);
    rd("datain_ro", 3'd2, 16'hFFFF);

    // Input synchroniser latency
    pad_in = 16'h0000;
    repeat (S + 3) tick();
    wr(3'd5, 16'hFFFF);
    pad_in = 16'h0004;
    rd("sync_e1", 3'd2, 16'h0000);
    rd("sync_e2", 3'd2, 16'h0000);
    rd("stat_e3", 3'd5, 16'h0000);
    rd("stat_e4", 3'd5, 16'h0004);
    rd("sync_e5", 3'd2, 16'h0004);
    chk("model_stat", m_stat, 16'h0004);

    // Falling edge select and irq
    wr(3'd5, 16'hFFFF);
    wr(3'd4, 16'hFFFB);
    wr(3'd3, 16'h0004);
    pad_in = 16'h0000;
    repeat (S + 2) tick();
    chk("fall_irq", irq, 1);
    rd("fall_status", 3'd5, 16'h0004);
    wr(3'd5, 16'h0004);
    chk("w1c_irq", irq, 0);

    // Set wins over coincident clear
    pad_in = 16'h0004;
    repeat (S + 3) tick();
    rd("rise_ignored", 3'd5, 16'h0000);
    pad_in = 16'h0000;
    tick(); tick();
    wr(3'd5, 16'h0004);
    rd("collide_status", 3'd5, 16'h0004);
    chk("collide_irq", irq, 1);
    wr(3'd5, 16'h0004);

    // Async reset in the middle of a read
    wr(3'd4, 16'hFFFF);
    pad_in = 16'h0004;
    repeat (S + 2) tick();
    chk("pre_rst_irq", irq, 1);
    bus_re = 1'b1; bus_addr = 3'd0;
    tick();
    bus_re = 1'b0;
    chk("pre_rst_rvalid", bus_rvalid, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_pad_out", pad_out, 0);
    chk("arst_pad_oe", pad_oe, 0);
    chk("arst_irq", irq, 0);
    chk("arst_rvalid", bus_rvalid, 0);
    chk("arst_rdata", bus_rdata, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rvalid", bus_rvalid, 0);
    end
    repeat (S + 2) tick();
    rd("post_rst_status", 3'd5, 16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus_we    = ($urandom_range(0, 2) == 0);
      bus_re    = ($urandom_range(0, 1) == 0);
      bus_addr  = 3'($urandom_range(0, 7));
      bus_wdata = 16'($urandom);
      if ($urandom_range(0, 5) == 0)
        pad_in = 16'($urandom);
      else if ($urandom_range(0, 3) == 0)
        pad_in = pad_in ^ (16'h1 << $urandom_range(0, 15));
      tick();
    end
    bus_we = 1'b0; bus_re = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of GPIO pins, data width and register width; legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth; legal range 2..4.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port bus_we, input, 1: write strobe, one write per cycle high.
REQ-006 SHALL have port bus_re, input, 1: read strobe.
REQ-007 SHALL have port bus_addr, input, 3: register select.
REQ-008 SHALL have port bus_wdata, input, WIDTH: write data.
REQ-009 SHALL have port bus_rdata, output, WIDTH: registered read data.
REQ-010 SHALL have port bus_rvalid, output, 1: high for one cycle when bus_rdata is valid.
REQ-011 SHALL have port pad_in, input, WIDTH: asynchronous pad input levels.
REQ-012 SHALL have port pad_out, output, WIDTH: pad drive values.
REQ-013 SHALL have port pad_oe, output, WIDTH: per-pin output enable, 1 = drive.
REQ-014 SHALL have port irq, output, 1: level interrupt request.

Function
REQ-015 SHALL decode bus_addr as follows: 0 DATA_OUT (RW), 1 DIR (RW), 2 DATA_IN (RO), 3 IRQ_EN (RW), 4 EDGE_SEL (RW, 1 = rising, 0 = falling), 5 IRQ_STATUS (RO, write-1-to-clear), 6 SET (WO), 7 CLR (WO).
REQ-016 SHALL drive pad_out directly from DATA_OUT and pad_oe directly from DIR.
REQ-017 SHALL apply a write to SET as DATA_OUT |= bus_wdata, and a write to CLR as DATA_OUT &= ~bus_wdata.
REQ-018 SHALL make a write visible on its register and on pad_out/pad_oe at the clock edge that samples bus_we.
REQ-019 SHALL ignore writes to DATA_IN.
REQ-020 SHALL register bus_rdata and pulse bus_rvalid on the edge after bus_re is sampled (1-cycle read latency).
REQ-021 SHALL return 0 for reads of SET and CLR.
REQ-022 SHALL hold bus_rdata when bus_re is low.
REQ-023 SHALL return the pre-write value when a read and a write hit the same register in the same cycle.
REQ-024 SHALL pass each pad_in bit through a SYNC_STAGES-deep flip-flop chain; DATA_IN is the last stage.
REQ-025 SHALL register the last synchroniser stage into prev.
REQ-026 SHALL detect a rising edge as sync & ~prev and a falling edge as ~sync & prev, selected per bit by EDGE_SEL.
REQ-027 SHALL set the IRQ_STATUS bit on a selected edge regardless of IRQ_EN.
REQ-028 SHALL set the IRQ_STATUS bit at clock edge SYNC_STAGES+1 after the first edge sampling the new pad_in level.
REQ-029 SHALL detect edges on a pin whether it is in input or output mode.
REQ-030 SHALL clear an IRQ_STATUS bit on a write of 1 to that bit position.
REQ-031 SHALL let a set win over a clear when a new event and a W1C on the same bit occur in the same cycle (bit stays 1).
REQ-032 SHALL drive irq = |(IRQ_STATUS & IRQ_EN), combinational from registers.
REQ-033 SHALL not let an IRQ_EN change alter IRQ_STATUS.
REQ-034 SHALL suppress edge events for SYNC_STAGES+1 cycles after reset deassertion, using a warm-up counter, so pads held high at reset do not flag edges.
REQ-035 SHALL enable event detection while the warm-up counter is saturated.
REQ-036 SHALL have no combinational path from pad_in to any output.

Reset
REQ-037 SHALL clear DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, synchronisers, prev, bus_rdata, bus_rvalid and the warm-up counter to 0 while rst is high.
REQ-038 SHALL hold pad_out = 0, pad_oe = 0 and irq = 0 while rst is high.
REQ-039 SHALL set EDGE_SEL to all-ones (rising) on reset.
REQ-040 SHALL discard any transaction in flight when rst asserts mid-read; no bus_rvalid pulse follows.

Verification
REQ-041 SHALL cover output path: write DIR=0x00FF, DATA_OUT=0x0F0F, then SET 0xF000 and CLR 0x000F -> pad_oe=0x00FF, pad_out=0xFF00; reading addr 0 returns 0xFF00 with bus_rvalid one cycle after bus_re.
REQ-042 SHALL cover input sync latency: pad_in 0x0000->0x0004 -> DATA_IN reads 0x0004 only after 2 edges (SYNC_STAGES=2); IRQ_STATUS bit 2 sets on edge 3.
REQ-043 SHALL cover edge select and irq: EDGE_SEL=0xFFFB, IRQ_EN=0x0004, pad_in bit 2 1->0 -> IRQ_STATUS=0x0004 and irq=1; write 0x0004 to addr 5 -> irq=0 next cycle.
REQ-044 SHALL cover set-over-clear collision: a new bit-2 event coincides with a W1C of 0x0004 -> IRQ_STATUS remains 0x0004.
REQ-045 SHALL cover reset warm-up: pad_in=0xFFFF held through reset release -> IRQ_STATUS stays 0x0000 and DATA_IN reads 0xFFFF after warm-up.
REQ-046 SHALL cover async reset: rst pulsed between clock edges mid-read -> all outputs 0 immediately, no bus_rvalid after release.
